// File: rtl/data_dump_tx_pkg.sv
// Shared constants, state encodings and helpers for the data-memory UART dump block.
package data_dump_tx_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned STOP_BITS        = 2;
  localparam int unsigned CLKS_PER_BIT_DEF = 64;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned BYTES_PER_WORD   = WORD_W / DATA_BITS;
  localparam int unsigned BYTE_IDX_W       = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    C_IDLE,
    C_READ,
    C_WAIT,
    C_SEND,
    C_NEXT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  // Byte idx of a word, idx 0 being bits [7:0].
  function automatic logic [DATA_BITS-1:0] byte_of(input logic [WORD_W-1:0]     word,
                                                   input logic [BYTE_IDX_W-1:0] idx);
    logic [WORD_W-1:0] sh;
    sh = word >> {idx, 3'b000};
    return sh[DATA_BITS-1:0];
  endfunction

endpackage

// File: rtl/data_dump_tx_if.sv
// Data-memory read port: one-cycle read strobe, data valid the following cycle.
interface data_dump_tx_if
  import data_dump_tx_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N2 UART byte serializer; reset is active-low, txd is a register that idles high.
module uart_tx_byte
  import data_dump_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 txd,
  output logic                 ready,
  output logic                 byte_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  ser_state_t           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [STOP_W-1:0]    stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_d, ready_d, done_d;
  logic                 bit_end_c;

  assign bit_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state: every line level is held for exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    txd_d   = txd;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          shift_d = data;
          baud_d  = '0;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = S_STOP;
            stop_d  = '0;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (stop_q == STOP_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + STOP_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      stop_q    <= '0;
      shift_q   <= '0;
      txd       <= 1'b1;
      ready     <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      txd       <= txd_d;
      ready     <= ready_d;
      byte_done <= done_d;
    end
  end

endmodule

// File: rtl/data_dump_tx.sv
// Dumps NUM_WORDS data-memory words over UART (4 bytes per word, LSB byte first)
// on each rising edge of Enable_Data_Output seen while idle.
module data_dump_tx
  import data_dump_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic           CLOCK_50,
  input  logic           rst,
  input  logic           Enable_Data_Output,
  data_dump_tx_if.master mem,
  output logic           UART_TxD,
  output logic           busy,
  output logic           done
);

  localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  ctrl_state_t           state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0]  tx_byte_q, tx_byte_d;
  logic                  rd_en_q, rd_en_d;
  logic                  load_q, load_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  en_prev_q;
  logic                  ser_ready, ser_done;
  logic                  start_c;

  assign start_c = Enable_Data_Output & ~en_prev_q & ~busy_q;

  // Next-state: byte 0 of a word is issued straight from WAIT when the line is free,
  // and the next word is fetched while byte 3 is still on the line.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;
    rd_en_d   = 1'b0;
    load_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (start_c) begin
          state_d = C_READ;
          addr_d  = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      C_READ: state_d = C_WAIT;
      C_WAIT: begin
        word_d  = mem.mem_rdata;
        state_d = C_SEND;
        idx_d   = '0;
        if (ser_ready && !load_q) begin
          load_d    = 1'b1;
          tx_byte_d = byte_of(mem.mem_rdata, BYTE_IDX_W'(0));
          idx_d     = BYTE_IDX_W'(1);
        end
      end
      C_SEND: begin
        if (ser_ready && !load_q) begin
          load_d    = 1'b1;
          tx_byte_d = byte_of(word_q, idx_q);
          if (idx_q == LAST_IDX) begin
            state_d = C_NEXT;
          end else begin
            idx_d = idx_q + BYTE_IDX_W'(1);
          end
        end
      end
      C_NEXT: begin
        if (addr_q != LAST_ADDR) begin
          addr_d  = addr_q + ADDR_W'(1);
          rd_en_d = 1'b1;
          state_d = C_READ;
        end else if (ser_done) begin
          state_d = C_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q   <= C_IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      tx_byte_q <= '0;
      rd_en_q   <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      tx_byte_q <= tx_byte_d;
      rd_en_q   <= rd_en_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_prev_q <= Enable_Data_Output;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock    (CLOCK_50),
    .reset    (rst),
    .load     (load_q),
    .data     (tx_byte_q),
    .txd      (UART_TxD),
    .ready    (ser_ready),
    .byte_done(ser_done)
  );

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_data_dump_tx.sv
// Bench for data_dump_tx: two instances (16 clk/bit x 16 words, 64 clk/bit x 1 word)
// checked against a line-waveform model built from memory contents.
module tb_data_dump_tx;
  import data_dump_tx_pkg::*;

  localparam int unsigned NW_A  = 16;
  localparam int unsigned CPB_A = 16;
  localparam int unsigned NW_B  = 1;
  localparam int unsigned CPB_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, txd_a, busy_a, done_a;
  logic rst_b, en_b, txd_b, busy_b, done_b;

  data_dump_tx_if #(.ADDR_W(8)) ifa ();
  data_dump_tx_if #(.ADDR_W(8)) ifb ();

  data_dump_tx #(.CLKS_PER_BIT(CPB_A), .NUM_WORDS(NW_A), .ADDR_W(8)) dut_a (
    .CLOCK_50(clk), .rst(rst_a), .Enable_Data_Output(en_a), .mem(ifa),
    .UART_TxD(txd_a), .busy(busy_a), .done(done_a));

  data_dump_tx #(.CLKS_PER_BIT(CPB_B), .NUM_WORDS(NW_B), .ADDR_W(8)) dut_b (
    .CLOCK_50(clk), .rst(rst_b), .Enable_Data_Output(en_b), .mem(ifb),
    .UART_TxD(txd_b), .busy(busy_b), .done(done_b));

  logic [31:0] mem_a [NW_A];
  logic [31:0] mem_b0;

  always @(posedge clk) if (ifa.mem_rd_en)
    ifa.mem_rdata <= (ifa.mem_addr < 8'(NW_A)) ? mem_a[ifa.mem_addr[3:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (ifb.mem_rd_en)
    ifb.mem_rdata <= (ifb.mem_addr == 8'd0) ? mem_b0 : 32'hDEAD_BEEF;

  int n_vec = 0;
  int n_bad = 0;

  logic sel_a = 1'b0;
  logic cap_on = 1'b0;
  logic txd_m, busy_m, done_m, rd_m;
  logic [7:0] addr_m;
  assign txd_m  = sel_a ? txd_a  : txd_b;
  assign busy_m = sel_a ? busy_a : busy_b;
  assign done_m = sel_a ? done_a : done_b;
  assign rd_m   = sel_a ? ifa.mem_rd_en : ifb.mem_rd_en;
  assign addr_m = sel_a ? ifa.mem_addr  : ifb.mem_addr;

  logic cap_q[$];
  int   rd_addr_q[$];
  int   done_cnt;

  always @(negedge clk) if (cap_on) begin
    cap_q.push_back(txd_m);
    if (rd_m) rd_addr_q.push_back(int'(addr_m));
    if (done_m) done_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_max(input string name, input longint act, input longint lim);
    n_vec++;
    if (act > lim) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
    end
  endtask

  task automatic cap_start();
    cap_q.delete();
    rd_addr_q.delete();
    done_cnt = 0;
    cap_on   = 1'b1;
  endtask

  // Walk the captured line: idle-high runs, then exact 11*n-cycle frames.
  task automatic analyze(input string tag, input int n, input logic [7:0] exp_b[$]);
    int p = 0;
    int run, errs, nz, idx;
    logic [7:0] rx, eb;
    logic ebit;
    for (int f = 0; f < exp_b.size(); f++) begin
      run = 0;
      while (p < cap_q.size() && cap_q[p] == 1'b1) begin p++; run++; end
      if (p >= cap_q.size()) begin
        chk($sformatf("%s_frame%0d_present", tag, f), 0, 1);
        return;
      end
      if (f == 0) chk_max($sformatf("%s_latency", tag), run, 4);
      else        chk_max($sformatf("%s_gap%0d", tag, f), run, 3);
      eb = exp_b[f];
      errs = 0;
      rx = '0;
      for (int b = 0; b < 11; b++) begin
        ebit = (b == 0) ? 1'b0 : (b <= 8) ? eb[b-1] : 1'b1;
        for (int c = 0; c < n; c++) begin
          idx = p + b*n + c;
          if (idx >= cap_q.size() || cap_q[idx] != ebit) errs++;
        end
        idx = p + b*n + n/2;
        if (b >= 1 && b <= 8 && idx < cap_q.size()) rx[b-1] = cap_q[idx];
      end
      chk($sformatf("%s_wave%0d", tag, f), errs, 0);
      chk($sformatf("%s_byte%0d", tag, f), rx, eb);
      p += 11*n;
    end
    nz = 0;
    while (p < cap_q.size()) begin if (cap_q[p] == 1'b0) nz++; p++; end
    chk($sformatf("%s_extra_low", tag), nz, 0);
  endtask

  // Wait for done, let the line settle, then check the whole dump.
  task automatic finish_dump(input string tag, input int n, input int nw,
                             input logic [7:0] exp_b[$]);
    int k = 0;
    int bad_addr = 0;
    while (done_cnt == 0 && k < nw*4*11*n + 500) begin @(negedge clk); k++; end
    chk($sformatf("%s_done_seen", tag), (done_cnt > 0) ? 1 : 0, 1);
    repeat (300) @(negedge clk);
    @(posedge clk);
    cap_on = 1'b0;
    analyze(tag, n, exp_b);
    chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
    chk($sformatf("%s_rd_cnt", tag), rd_addr_q.size(), nw);
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != i) bad_addr++;
    chk($sformatf("%s_rd_addr_seq", tag), bad_addr, 0);
    @(negedge clk);
    chk($sformatf("%s_busy_end", tag), busy_m, 0);
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       txd;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] exp_b[$];
    int lows, bhi, rdh;

    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    mem_b0 = 32'h0000_0001;
    for (int i = 0; i < NW_A; i++) mem_a[i] = 32'h4433_2211 + 32'(i);

    // Reset, start-edge timing and async reset on instance B.
    tbl[0]  = '{rst:1'b0, en:1'b0, txd:1'b1, busy:1'b0, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[1]  = '{rst:1'b0, en:1'b1, txd:1'b1, busy:1'b0, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[2]  = '{rst:1'b1, en:1'b0, txd:1'b1, busy:1'b0, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[3]  = '{rst:1'b1, en:1'b0, txd:1'b1, busy:1'b0, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[4]  = '{rst:1'b1, en:1'b1, txd:1'b1, busy:1'b0, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[5]  = '{rst:1'b1, en:1'b1, txd:1'b1, busy:1'b1, done:1'b0, rd_en:1'b1, addr:8'd0};
    tbl[6]  = '{rst:1'b1, en:1'b0, txd:1'b1, busy:1'b1, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[7]  = '{rst:1'b1, en:1'b0, txd:1'b1, busy:1'b1, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[8]  = '{rst:1'b1, en:1'b0, txd:1'b0, busy:1'b1, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[9]  = '{rst:1'b1, en:1'b0, txd:1'b0, busy:1'b1, done:1'b0, rd_en:1'b0, addr:8'd0};
    tbl[10] = '{rst:1'b0, en:1'b0, txd:1'b1, busy:1'b0, done:1'b0, rd_en:1'b0, addr:8'd0};

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      rst_b = tbl[i].rst;
      en_b  = tbl[i].en;
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i),
          {txd_b, busy_b, done_b, ifb.mem_rd_en, ifb.mem_addr},
          {tbl[i].txd, tbl[i].busy, tbl[i].done, tbl[i].rd_en, tbl[i].addr});
    end

    chk("a_reset_outs", {txd_a, busy_a, done_a, ifa.mem_rd_en, ifa.mem_addr}, 12'h800);

    // Single word 0x00000001 at 64 clk/bit, enable pulsed.
    @(posedge clk); #1; rst_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    sel_a = 1'b0; en_b = 1'b1; cap_start();
    repeat (3) @(posedge clk); #1; en_b = 1'b0;
    repeat (50) @(negedge clk);
    chk("b1_busy_mid", busy_b, 1);
    exp_b = '{8'h01, 8'h00, 8'h00, 8'h00};
    finish_dump("b1", CPB_B, NW_B, exp_b);

    // Reset during bit 4 of the second frame truncates it; line stays idle afterwards.
    @(posedge clk); #1; en_b = 1'b1;
    repeat (3) @(posedge clk); #1; en_b = 1'b0;
    repeat (997) @(posedge clk); #2;
    chk("b2_busy_pre", busy_b, 1);
    chk("b2_txd_pre", txd_b, 0);
    rst_b = 1'b0; #1;
    chk("b2_rst_outs", {txd_b, busy_b, done_b, ifb.mem_rd_en, ifb.mem_addr}, 12'h800);
    @(posedge clk); #1; rst_b = 1'b1;
    lows = 0; bhi = 0; rdh = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!txd_b) lows++;
      if (busy_b) bhi++;
      if (ifb.mem_rd_en) rdh++;
    end
    chk("b2_idle_txd_low", lows, 0);
    chk("b2_idle_busy", bhi, 0);
    chk("b2_idle_rd", rdh, 0);

    // Enable high across reset release starts one dump; dropping it mid-dump does not abort.
    mem_b0 = $urandom;
    @(posedge clk); #1; rst_b = 1'b0; en_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("b3_in_reset_busy", busy_b, 0);
    @(posedge clk); #1; rst_b = 1'b1; cap_start();
    repeat (1000) @(posedge clk); #1; en_b = 1'b0;
    exp_b.delete();
    for (int b = 0; b < 4; b++) exp_b.push_back(8'(mem_b0 >> (8*b)));
    finish_dump("b3", CPB_B, NW_B, exp_b);

    // Instance A: fixed pattern, then random contents with a re-trigger mid-dump.
    @(posedge clk); #1; rst_a = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) for (int i = 0; i < NW_A; i++) mem_a[i] = $urandom;
      exp_b.delete();
      for (int w = 0; w < NW_A; w++)
        for (int b = 0; b < 4; b++) exp_b.push_back(8'(mem_a[w] >> (8*b)));
      @(posedge clk); #1;
      sel_a = 1'b1; en_a = 1'b1; cap_start();
      repeat (3) @(posedge clk); #1; en_a = 1'b0;
      repeat ($urandom_range(200, 8000)) @(posedge clk); #1;
      en_a = 1'b1;
      repeat (5) @(posedge clk); #1;
      en_a = 1'b0;
      @(negedge clk);
      chk($sformatf("a%0d_busy_mid", pass), busy_a, 1);
      finish_dump($sformatf("a%0d", pass), CPB_A, NW_A, exp_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_dump_tx.md
DATA_DUMP_TX -- requirements
Module: data_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 64, clock cycles per UART bit.
REQ-002 Parameter NUM_WORDS, default 16, data-memory words dumped per request.
REQ-003 Parameter ADDR_W, default 8, data-memory address width.
REQ-004 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port Enable_Data_Output  input  1  dump request; its rising edge starts one dump.
REQ-007 Port mem_rd_en  output  1  data-memory read strobe, one cycle per word.
REQ-008 Port mem_addr  output  ADDR_W  data-memory word address.
REQ-009 Port mem_rdata  input  32  read data, valid exactly one cycle after mem_rd_en.
REQ-010 Port UART_TxD  output  1  serial line, idle high.
REQ-011 Port busy  output  1  high from dump start through the last stop bit.
REQ-012 Port done  output  1  one-cycle pulse after the last stop bit of a dump.

Function
REQ-013 Frame format SHALL be 8N2: one start bit (0), 8 data bits LSB first, two stop bits (1); each bit lasts exactly CLKS_PER_BIT cycles, giving 11*CLKS_PER_BIT cycles per frame.
REQ-014 Each 32-bit word SHALL be sent as 4 frames, byte order [7:0], [15:8], [23:16], [31:24].
REQ-015 Words SHALL be sent in address order 0 to NUM_WORDS-1, with no wrap beyond NUM_WORDS-1.
REQ-016 Enable_Data_Output SHALL be edge-detected with a registered previous value; only a 0->1 transition while busy=0 starts a dump.
REQ-017 A rising edge while busy=1 SHALL be ignored, not queued.
REQ-018 A fall of Enable_Data_Output mid-dump SHALL NOT abort the dump.
REQ-019 Control FSM states: IDLE, READ (mem_rd_en=1), WAIT (latch mem_rdata), SEND (issue byte k of 4, wait for byte-done), NEXT (increment address or finish).
REQ-020 Control transitions: IDLE->READ on start edge; READ->WAIT; WAIT->SEND; SEND->SEND for bytes 0..2; SEND->NEXT after byte 3; NEXT->READ if address < NUM_WORDS-1, else ->IDLE with done pulse.
REQ-021 Latency from the start edge cycle to the UART_TxD falling edge of the first start bit SHALL be at most 4 cycles.
REQ-022 Consecutive frames SHALL have a gap of at most 3 idle-high cycles, including across word boundaries.
REQ-023 Byte-serializer FSM states: IDLE, START, DATA, STOP; it has a bit counter 0..7, a stop counter 0..1, and a baud counter 0..CLKS_PER_BIT-1.
REQ-024 The serializer SHALL accept a load only in IDLE and SHALL assert byte_done for one cycle at the end of the second stop bit.
REQ-025 UART_TxD SHALL be driven from a register and be glitch-free.
REQ-026 mem_rd_en SHALL be high for exactly NUM_WORDS cycles per dump.

Reset
REQ-027 On rst=0, the following SHALL take effect immediately regardless of clock: UART_TxD=1, busy=0, done=0, mem_rd_en=0, mem_addr=0, both FSMs in IDLE, all counters 0, edge-detect register 0.
REQ-028 Reset mid-frame SHALL truncate the frame; after release, no transmission occurs until a new rising edge.
REQ-029 If Enable_Data_Output is already high at reset release, a dump SHALL start (edge register resets to 0).

Structure
REQ-030 A shared package SHALL hold the frame constants (DATA_BITS=8, STOP_BITS=2), the default CLKS_PER_BIT, and the state encodings of both FSMs.
REQ-031 The byte serializer SHALL be the sub-module uart_tx_byte (ports: clock, reset, load, data[7:0], txd, ready, byte_done), reusable elsewhere.

Verification
REQ-032 mem[0]=0x00000001, NUM_WORDS=1, pulse enable -> TxD sequence 0,1,0,0,0,0,0,0,0,1,1, then 3 frames of 0x00; each bit exactly 64 cycles; done pulses once; busy drops.
REQ-033 mem[i]=0x44332211+i, NUM_WORDS=16 -> 64 frames decoded by a loopback receiver model match bytes LSB-first per word; mem_rd_en asserted exactly 16 times, addresses 0..15.
REQ-034 Second rising edge during a dump -> ignored; total frames remain 4*NUM_WORDS; no second done pulse.
REQ-035 Drop rst during bit 4 of frame 2 -> TxD=1 in the same cycle; after release with enable held low, TxD stays 1 for 2000 cycles.
REQ-036 Enable held high across reset release -> exactly one dump starts; enable lowered mid-dump -> dump completes.
REQ-037 CLKS_PER_BIT=16 -> each bit lasts 16 cycles; inter-frame gap is 3 cycles or fewer.
